// File: rtl/evm_pkg.sv
// Shared definitions for the voting pipeline: FSM state encoding, mode values
// and a one-hot test reused by the debouncer, logger and display stages.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2
  } state_t;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  // True when exactly one bit of v is set; callers zero-extend narrower vectors.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clear has
// priority over inc. at_max is decoded straight from the count register.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = &count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vote_logger.sv
// One-vote-per-ballot logger: arms on a ballot pulse, accepts a single one-hot
// vote into a saturating per-candidate tally, and shows a chosen tally in result mode.
module vote_logger
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] valid_vote,
  output logic                ballot_armed,
  output logic                vote_ack,
  output logic                vote_reject,
  output logic [CNT_W-1:0]    total_votes,
  output logic [SEL_W-1:0]    display_sel,
  output logic [CNT_W-1:0]    display_count
);

  state_t              state;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [NUM_CAND-1:0] tally_max;
  logic [NUM_CAND-1:0] tally_inc;
  logic                total_max;
  logic                single;
  logic [SEL_W-1:0]    idx;
  logic                voting;
  logic                accept;
  logic                refuse;

  always_comb begin
    single = is_onehot(16'(valid_vote));
    idx    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (valid_vote[i]) idx = SEL_W'(i);
    end
  end

  // Result mode takes priority over an open ballot, so it also suppresses accept/refuse.
  assign voting    = (mode == MODE_VOTE) && (state == ARMED) && (|valid_vote);
  assign accept    = voting && single && !tally_max[idx];
  assign refuse    = voting && !accept;
  assign tally_inc = accept ? valid_vote : '0;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
    sat_counter #(.CNT_W(CNT_W)) u_tally (
      .clock  (clock),
      .reset  (reset),
      .inc    (tally_inc[g]),
      .clear  (1'b0),
      .count  (tally[g]),
      .at_max (tally_max[g])
    );
  end

  // A full total only stops its own increment; the vote itself is still taken.
  sat_counter #(.CNT_W(CNT_W)) u_total (
    .clock  (clock),
    .reset  (reset),
    .inc    (accept && !total_max),
    .clear  (1'b0),
    .count  (total_votes),
    .at_max (total_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ballot_armed  <= 1'b0;
      vote_ack      <= 1'b0;
      vote_reject   <= 1'b0;
      display_sel   <= '0;
      display_count <= '0;
    end else begin
      vote_ack      <= 1'b0;
      vote_reject   <= 1'b0;
      display_count <= (mode == MODE_RESULT) ? tally[display_sel] : '0;
      if (mode == MODE_RESULT) begin
        state        <= IDLE;
        ballot_armed <= 1'b0;
        if (single) display_sel <= idx;
      end else begin
        case (state)
          IDLE: begin
            if (ballot_enable) begin
              state        <= ARMED;
              ballot_armed <= 1'b1;
            end
          end
          ARMED: begin
            if (accept) begin
              state        <= RECORD;
              ballot_armed <= 1'b0;
              vote_ack     <= 1'b1;
            end else if (refuse) begin
              vote_reject  <= 1'b1;
            end
          end
          RECORD:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
